telemetry_text_decoder: RTL and testbench

//  - Inverse of the telemetry text path: parses an ASCII byte stream of lines "<row>:<value>\n" (decimal) into binary per-signal value registers.
//  - Sits between the MCU byte receiver (SPI/UART byte stream) and the telemetry panel value[] inputs.
//  - Panel-rendered values can then be driven from host-side text without MCU binary packing.

---
 rtl/telemetry_text_decoder.sv | 201 ++++++++++++++++++++
 tb/tb_telemetry_text_decoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/telemetry_text_decoder.sv
// telemetry_text_decoder
//   Parses an ASCII stream of "<row>:<value>\n" lines (decimal) into binary
//   per-signal value registers for the telemetry panel.
//
//   Optional feature macro: TELEMETRY_DECODER_ERRCNT_EN adds err_count.
//
// Ports
//   clk           in   system clock
//   reset_n       in   asynchronous active-low reset
//   rx_data       in   received ASCII byte
//   rx_valid      in   rx_data valid this cycle
//   rx_ready      out  decoder accepts a byte (1 every cycle out of reset)
//   value         out  decoded value registers, one per row
//   update_valid  out  1-cycle pulse: a register was written
//   update_row    out  row written (valid with update_valid)
//   line_error    out  1-cycle pulse: malformed line detected
//   err_count     out  saturating line_error count (macro builds only)
module telemetry_text_decoder #(
    parameter int unsigned NUM_SIGNALS      = 7,
    parameter int unsigned VALUE_WIDTH      = 9,
    parameter int unsigned NUM_VALUE_DIGITS = 3,
    parameter int unsigned ROW_BITS         = (NUM_SIGNALS > 1) ? $clog2(NUM_SIGNALS) : 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [7:0]                            rx_data,
    input  logic                                  rx_valid,
    output logic                                  rx_ready,
    output logic [NUM_SIGNALS-1:0][VALUE_WIDTH-1:0] value,
    output logic                                  update_valid,
    output logic [ROW_BITS-1:0]                   update_row,
`ifdef TELEMETRY_DECODER_ERRCNT_EN
    output logic [15:0]                           err_count,
`endif
    output logic                                  line_error
);

    // Accumulator is wide enough that no legal digit sequence can wrap
    // before the range check at '\n' (4 bits/digit >= log2(10) bits/digit).
    localparam int unsigned VAL_W = (VALUE_WIDTH + 4 > 4 * NUM_VALUE_DIGITS) ?
                                    VALUE_WIDTH + 4 : 4 * NUM_VALUE_DIGITS;
    localparam int unsigned ND_W  = $clog2(NUM_VALUE_DIGITS + 1);
    localparam int unsigned RA_W  = 7;  // two decimal row digits, max 99
    localparam logic [VAL_W-1:0] VAL_MAX = VAL_W'((64'd1 << VALUE_WIDTH) - 64'd1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ROW,
        S_VALUE,
        S_DISCARD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [RA_W-1:0]   row_acc;
    logic [1:0]        row_digits;
    logic [VAL_W-1:0]  val_acc;
    logic [ND_W-1:0]   nd;

    logic accept;
    logic is_cr, is_lf, is_sp, is_colon, is_digit;
    logic [3:0] digit;
    logic row_ok, val_ok, nd_full;

    logic err_c, commit_c, row_first_c, row_next_c, val_clear_c, val_next_c;

    // Byte classification
    assign accept   = rx_valid && rx_ready;
    assign is_cr    = (rx_data == 8'h0D);
    assign is_lf    = (rx_data == 8'h0A);
    assign is_sp    = (rx_data == 8'h20);
    assign is_colon = (rx_data == 8'h3A);
    assign is_digit = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign digit    = rx_data[3:0];  // low nibble of '0'..'9' is the digit
    assign row_ok   = (32'(row_acc) < NUM_SIGNALS);
    assign val_ok   = (val_acc <= VAL_MAX);
    assign nd_full  = (nd == ND_W'(NUM_VALUE_DIGITS));

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; '\r' never changes state
    always_comb begin
        state_d = state_q;
        if (accept && !is_cr) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_digit)             state_d = S_ROW;
                    else if (!(is_lf || is_sp)) state_d = S_DISCARD;
                end
                S_ROW: begin
                    if (is_digit)       state_d = (row_digits == 2'd2) ? S_DISCARD : S_ROW;
                    else if (is_colon)  state_d = row_ok ? S_VALUE : S_DISCARD;
                    else                state_d = S_DISCARD;
                end
                S_VALUE: begin
                    if (is_sp && nd == '0) state_d = S_VALUE;
                    else if (is_digit)     state_d = nd_full ? S_DISCARD : S_VALUE;
                    else if (is_lf)        state_d = S_IDLE;
                    else                   state_d = S_DISCARD;
                end
                S_DISCARD: begin
                    if (is_lf) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Control decode: error/commit events and accumulator updates
    always_comb begin
        err_c       = 1'b0;
        commit_c    = 1'b0;
        row_first_c = 1'b0;
        row_next_c  = 1'b0;
        val_clear_c = 1'b0;
        val_next_c  = 1'b0;
        if (accept && !is_cr) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_digit)               row_first_c = 1'b1;
                    else if (!(is_lf || is_sp)) err_c = 1'b1;
                end
                S_ROW: begin
                    if (is_digit) begin
                        if (row_digits == 2'd2) err_c = 1'b1;
                        else                    row_next_c = 1'b1;
                    end else if (is_colon) begin
                        if (row_ok) val_clear_c = 1'b1;
                        else        err_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                S_VALUE: begin
                    if (is_sp && nd == '0) begin
                        err_c = 1'b0;
                    end else if (is_digit) begin
                        if (nd_full) err_c = 1'b1;
                        else         val_next_c = 1'b1;
                    end else if (is_lf) begin
                        if (nd == '0 || !val_ok) err_c = 1'b1;
                        else                     commit_c = 1'b1;
                    end else begin
                        err_c = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Accumulators, value registers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_ready     <= 1'b0;
            row_acc      <= '0;
            row_digits   <= '0;
            val_acc      <= '0;
            nd           <= '0;
            value        <= '0;
            update_valid <= 1'b0;
            update_row   <= '0;
            line_error   <= 1'b0;
        end else begin
            rx_ready     <= 1'b1;
            update_valid <= commit_c;
            line_error   <= err_c;
            if (row_first_c) begin
                row_acc    <= RA_W'(digit);
                row_digits <= 2'd1;
            end else if (row_next_c) begin
                row_acc    <= row_acc * RA_W'(10) + RA_W'(digit);
                row_digits <= row_digits + 2'd1;
            end
            if (val_clear_c) begin
                val_acc <= '0;
                nd      <= '0;
            end else if (val_next_c) begin
                val_acc <= val_acc * VAL_W'(10) + VAL_W'(digit);
                nd      <= nd + ND_W'(1);
            end
            if (commit_c) update_row <= row_acc[ROW_BITS-1:0];
            for (int unsigned i = 0; i < NUM_SIGNALS; i++) begin
                if (commit_c && row_acc == RA_W'(i)) value[i] <= val_acc[VALUE_WIDTH-1:0];
            end
        end
    end

`ifdef TELEMETRY_DECODER_ERRCNT_EN
    // Saturating malformed-line counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)                         err_count <= '0;
        else if (err_c && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_telemetry_text_decoder.sv
// Self-checking bench for telemetry_text_decoder (7 rows, 9-bit values, 3 digits).
module tb_telemetry_text_decoder;

    logic             clk = 1'b0;
    logic             reset_n;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             rx_ready;
    logic [6:0][8:0]  value;
    logic             update_valid;
    logic [2:0]       update_row;
    logic             line_error;
`ifdef TELEMETRY_DECODER_ERRCNT_EN
    logic [15:0]      err_count;
`endif

    telemetry_text_decoder #(
        .NUM_SIGNALS(7), .VALUE_WIDTH(9), .NUM_VALUE_DIGITS(3)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data(rx_data),
        .rx_valid(rx_valid),
        .rx_ready(rx_ready),
        .value(value),
        .update_valid(update_valid),
        .update_row(update_row),
`ifdef TELEMETRY_DECODER_ERRCNT_EN
        .err_count(err_count),
`endif
        .line_error(line_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        string text;
        bit    commit;
        int    row;
        int    val;
        int    errs;
    } vec_t;

    vec_t            vecs[16];
    logic [6:0][8:0] exp_value;
    int              n_cmp  = 0;
    int              n_fail = 0;
    int              upd_cnt = 0;
    int              err_cnt = 0;
    int              both_cnt = 0;
    int              last_row = 0;
    int              tot_err = 0;

    // Pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (update_valid) begin
            upd_cnt++;
            last_row = int'(update_row);
        end
        if (line_error) err_cnt++;
        if (update_valid && line_error) both_cnt++;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            rx_data  = s[i];
            rx_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'h78;  // garbage while not valid
    endtask

    task automatic settle_and_check(input string name, input int exp_upd, input int exp_err);
        repeat (2) @(posedge clk);
        #1;
        check({name, " update_cnt"}, 64'(upd_cnt), 64'(exp_upd));
        check({name, " error_cnt"}, 64'(err_cnt), 64'(exp_err));
        check({name, " values"}, 64'(value), 64'(exp_value));
`ifdef TELEMETRY_DECODER_ERRCNT_EN
        check({name, " err_count"}, 64'(err_count), 64'(tot_err));
`endif
    endtask

    initial begin
        vecs[0]  = '{"3:123\n",               1, 3, 123, 0};
        vecs[1]  = '{"6: 511\015\n",          1, 6, 511, 0};
        vecs[2]  = '{"2:512\n",               0, 0, 0,   1};
        vecs[3]  = '{"2:\n",                  0, 0, 0,   1};
        vecs[4]  = '{"7:5\n",                 0, 0, 0,   1};
        vecs[5]  = '{"12:1\n",                0, 0, 0,   1};
        vecs[6]  = '{"1:1x9\n",               0, 0, 0,   1};
        vecs[7]  = '{"\n",                    0, 0, 0,   0};
        vecs[8]  = '{"0:0\n",                 1, 0, 0,   0};
        vecs[9]  = '{"5:  007\n",             1, 5, 7,   0};
        vecs[10] = '{"a:1\n",                 0, 0, 0,   1};
        vecs[11] = '{"4:5 \n",                0, 0, 0,   1};
        vecs[12] = '{"99:1\n",                0, 0, 0,   1};
        vecs[13] = '{"123:4\n",               0, 0, 0,   1};
        vecs[14] = '{"\0153\015:\0154\015\n", 1, 3, 4,   0};
        vecs[15] = '{"1:1:2\n",               0, 0, 0,   1};

        reset_n   = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'h00;
        exp_value = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset rx_ready", 64'(rx_ready), 64'd0);
        check("reset values", 64'(value), 64'd0);
        check("reset update_valid", 64'(update_valid), 64'd0);
        check("reset update_row", 64'(update_row), 64'd0);
        check("reset line_error", 64'(line_error), 64'd0);
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rx_ready after reset", 64'(rx_ready), 64'd1);
        upd_cnt = 0;
        err_cnt = 0;

        // Table-driven single lines
        for (int v = 0; v < 16; v++) begin
            upd_cnt = 0;
            err_cnt = 0;
            send_str(vecs[v].text);
            if (vecs[v].commit) exp_value[vecs[v].row] = 9'(vecs[v].val);
            tot_err += vecs[v].errs;
            settle_and_check($sformatf("vec%0d", v), vecs[v].commit ? 1 : 0, vecs[v].errs);
            if (vecs[v].commit) begin
                check($sformatf("vec%0d update_row", v), 64'(last_row), 64'(vecs[v].row));
                check($sformatf("vec%0d value", v), 64'(value[vecs[v].row]), 64'(vecs[v].val));
            end
        end

        // Back-to-back lines: too many digits, then a good line
        upd_cnt = 0;
        err_cnt = 0;
        send_str("4:1234\n4:9\n");
        exp_value[4] = 9'd9;
        tot_err += 1;
        settle_and_check("b2b", 1, 1);
        check("b2b update_row", 64'(last_row), 64'd4);

        // rx_valid gaps mid-line hold state
        upd_cnt = 0;
        err_cnt = 0;
        send_str("2:");
        repeat (3) @(posedge clk);
        #1;
        send_str("4");
        repeat (2) @(posedge clk);
        #1;
        send_str("5\n");
        exp_value[2] = 9'd45;
        settle_and_check("gap", 1, 0);

        // Reset mid-line discards the partial line and clears all values
        send_str("5:12");
        reset_n = 1'b0;
        #2;
        check("midreset rx_ready", 64'(rx_ready), 64'd0);
        check("midreset values", 64'(value), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        upd_cnt = 0;
        err_cnt = 0;
        exp_value = '0;
        tot_err = 0;
        send_str("0:7\n");
        exp_value[0] = 9'd7;
        settle_and_check("post-reset", 1, 0);
        check("post-reset value5", 64'(value[5]), 64'd0);
        check("post-reset value0", 64'(value[0]), 64'd7);

        check("error/update coincident", 64'(both_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
